// File: rtl/seq_finder.sv
// rtl/seq_finder.sv - serial pattern detector with configurable length, overlap and saturating match count
module seq_finder #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               serial_in,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap_en,
  input  logic               count_clr,
  output logic               sqce_found,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat
);

  typedef enum logic [1:0] {IDLE, FILL, HUNT} state_t;

  state_t             state, state_nx;
  logic [MAX_LEN-1:0] hist, hist_nx;
  logic [MAX_LEN-1:0] cfg_pattern, cfg_pattern_nx;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill, fill_nx, fill_inc;
  logic [LEN_W-1:0]   cfg_len, cfg_len_nx, len_clamped;
  logic               cfg_overlap, cfg_overlap_nx;
  logic               match;
  logic [CNT_W-1:0]   count_nx;

  // Lengths beyond the history depth are treated as the full depth
  always_comb begin
    len_clamped = (pat_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : pat_len;
  end

  // Select the low cfg_len history bits that take part in the compare
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(cfg_len));
    end
  end

  // Fill count of fresh bits, saturating at the history depth
  always_comb begin
    fill_inc = (fill >= LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
  end

  // Next-state: config load wins over data; match judged on the updated history
  always_comb begin
    state_nx       = state;
    hist_nx        = hist;
    fill_nx        = fill;
    cfg_pattern_nx = cfg_pattern;
    cfg_len_nx     = cfg_len;
    cfg_overlap_nx = cfg_overlap;
    match          = 1'b0;
    if (cfg_load) begin
      hist_nx        = '0;
      fill_nx        = '0;
      cfg_pattern_nx = pattern;
      cfg_len_nx     = len_clamped;
      cfg_overlap_nx = overlap_en;
      state_nx       = (len_clamped == '0) ? IDLE : FILL;
    end else if (in_valid) begin
      hist_nx = {hist[MAX_LEN-2:0], serial_in};
      fill_nx = fill_inc;
      if (state != IDLE) begin
        state_nx = (fill_inc >= cfg_len) ? HUNT : FILL;
        match    = (state_nx == HUNT) &&
                   ((hist_nx & len_mask) == (cfg_pattern & len_mask));
        if (match && !cfg_overlap) begin
          fill_nx  = '0;
          state_nx = FILL;
        end
      end
    end
  end

  // Match counter: clear wins over a simultaneous match, otherwise saturate
  always_comb begin
    count_nx = match_count;
    if (count_clr) begin
      count_nx = '0;
    end else if (match && !count_sat) begin
      count_nx = match_count + CNT_W'(1);
    end
  end

  assign count_sat = &match_count;

  // State, history, latched configuration and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hist        <= '0;
      fill        <= '0;
      cfg_pattern <= '0;
      cfg_len     <= '0;
      cfg_overlap <= 1'b0;
      sqce_found  <= 1'b0;
      match_count <= '0;
    end else begin
      state       <= state_nx;
      hist        <= hist_nx;
      fill        <= fill_nx;
      cfg_pattern <= cfg_pattern_nx;
      cfg_len     <= cfg_len_nx;
      cfg_overlap <= cfg_overlap_nx;
      sqce_found  <= match;
      match_count <= count_nx;
    end
  end

endmodule

// File: doc/seq_finder.md
SEQ_FINDER -- requirements
Module: seq_finder

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, meaning the maximum pattern length in bits (range 2..32).
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of the match counter.
REQ-003 SHALL have local width LEN_W = $clog2(MAX_LEN+1).
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  meaning reset; reset is asynchronous and active-low.
REQ-006 SHALL have port serial_in  input  1  meaning the serial data bit.
REQ-007 SHALL have port in_valid  input  1  meaning serial_in is sampled this edge.
REQ-008 SHALL have port cfg_load  input  1  meaning latch pattern, pat_len and overlap_en this edge.
REQ-009 SHALL have port pattern  input  MAX_LEN  meaning the target sequence; pattern[pat_len-1] is the first bit expected.
REQ-010 SHALL have port pat_len  input  LEN_W  meaning the active pattern length.
REQ-011 SHALL have port overlap_en  input  1  meaning 1 allows overlapping matches, 0 requires fresh bits after each match.
REQ-012 SHALL have port count_clr  input  1  meaning synchronous clear of match_count.
REQ-013 SHALL have port sqce_found  output  1  meaning a registered one-cycle match pulse.
REQ-014 SHALL have port match_count  output  CNT_W  meaning the number of matches, saturating.
REQ-015 SHALL have port count_sat  output  1  meaning match_count has saturated at all-ones.

Function
REQ-016 SHALL shift each bit in on an edge with in_valid=1; the newest bit enters hist[0], and older bits move toward hist[MAX_LEN-1].
REQ-017 SHALL ignore serial_in on edges with in_valid=0; hist, fill and sqce_found=0 apply on those edges.
REQ-018 SHALL keep a fill counter of valid bits since the last cfg_load or non-overlap match, saturating at MAX_LEN.
REQ-019 SHALL use internal FSM states IDLE (cfg_len==0), FILL (fill < cfg_len) and HUNT (fill >= cfg_len).
REQ-020 SHALL, on cfg_load, go to IDLE if the clamped pat_len is 0 and to FILL otherwise; FILL goes to HUNT when fill reaches cfg_len; a non-overlap match goes from HUNT to FILL.
REQ-021 SHALL clamp a latched pat_len greater than MAX_LEN to MAX_LEN; pat_len=0 disables matching.
REQ-022 SHALL define a match as: state HUNT after the update, and new hist[cfg_len-1:0] == cfg_pattern[cfg_len-1:0].
REQ-023 SHALL register sqce_found at the same edge that shifts in the completing bit, high for exactly one cycle; latency is 0 cycles after that edge.
REQ-024 SHALL, on a match with cfg_overlap=0, clear fill to 0 at the same edge.
REQ-025 SHALL, on a match with cfg_overlap=1, leave fill unchanged.
REQ-026 SHALL increment match_count by 1 per match, saturating at 2^CNT_W-1.
REQ-027 SHALL assert count_sat whenever match_count equals all-ones.
REQ-028 SHALL give cfg_load priority over in_valid on the same edge: the bit is discarded, fill=0, hist is cleared, sqce_found=0, and match_count is kept.
REQ-029 SHALL give count_clr priority over a simultaneous match: match_count=0 and count_sat=0, while sqce_found still pulses.
REQ-030 SHALL take a changed pattern, pat_len or overlap_en value only on cfg_load; all comparisons use the latched copies.

Reset
REQ-031 SHALL, on rst_n=0, immediately clear hist, fill, cfg_pattern, cfg_len and cfg_overlap to 0, set state IDLE, and clear sqce_found, match_count and count_sat to 0.
REQ-032 SHALL, on rst_n=0 mid-stream, discard any partial sequence; after release no match occurs until a cfg_load with nonzero pat_len.

Verification
REQ-033 SHALL be checked with MAX_LEN=8: load 1011, len 4, overlap=1; stream 1,0,1,1,0,1,1 -> sqce_found after bits 4 and 7, match_count=2.
REQ-034 SHALL be checked with the same stream and overlap=0 -> single pulse after bit 4, match_count=1.
REQ-035 SHALL be checked with pattern 111, len 3: stream 1,1,1,1,1 -> overlap=1 gives pulses after bits 3, 4 and 5 (count 3); overlap=0 gives a pulse after bit 3 only (count 1).
REQ-036 SHALL be checked with pattern 10, len 2: bits 1,(in_valid=0, serial_in=1),0 -> one pulse after the third edge; cfg_load together with the completing bit -> no pulse.
REQ-037 SHALL be checked with CNT_W=4, pattern 1, len 1, overlap=1: 20 ones -> match_count=15, count_sat=1; then count_clr -> 0 and 0.
REQ-038 SHALL be checked with rst_n low after 3 bits of 1011 -> outputs 0 at once; after release, a 1011 stream gives no pulse until reload.
